// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM burst read path: reader FSM encoding and the
// credit depth of the output skid buffer.
package bram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } reader_state_e;

   localparam int STREAM_CREDITS = 2;

   // occupancy counts buffered words (after any pop this cycle) plus the read in flight
   function automatic logic credit_available(input logic [2:0] occupancy);
      return occupancy < 3'(STREAM_CREDITS);
   endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer; head entry drives the stream, push and pop may
// happen in the same cycle.
module stream_skid2 #(
   parameter int width_p = 17
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] push_data_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [width_p-1:0] head_o,
   output logic [1:0]         count_o,
   output logic               pop_o
);

   logic [width_p-1:0] entry0;
   logic [width_p-1:0] entry1;
   logic [1:0]         count;

   assign valid_o = (count != 2'd0);
   assign pop_o   = valid_o && ready_i;
   assign head_o  = entry0;
   assign count_o = count;

   // entry0 is only rewritten while empty or while being popped, so a stalled head holds still
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         entry0 <= '0;
         entry1 <= '0;
         count  <= 2'd0;
      end else begin
         assert (!(push_i && !pop_o && count == 2'd2));
         unique case ({push_i, pop_o})
            2'b10: begin
               if (count == 2'd0) begin
                  entry0 <= push_data_i;
               end else begin
                  entry1 <= push_data_i;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  entry0 <= entry1;
                  entry1 <= push_data_i;
               end else begin
                  entry0 <= push_data_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read engine for the init_bram read port: issues sequential reads and
// presents the words as a valid/ready stream with a last marker.
module bram_stream_reader
   import bram_pkg::*;
#(
   parameter int memSize_p   = 8,
   parameter int dataWidth_p = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   start_i,
   input  logic [memSize_p-1:0]   base_addr_i,
   input  logic [memSize_p:0]     length_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic                   bram_wr_i,
   output logic                   bram_read_o,
   output logic [memSize_p-1:0]   bram_raddr_o,
   input  logic [dataWidth_p-1:0] bram_data_i,
   output logic [dataWidth_p-1:0] data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   last_o
);

   localparam logic [memSize_p-1:0] ADDR_ONE  = memSize_p'(1);
   localparam logic [memSize_p:0]   COUNT_ONE = (memSize_p + 1)'(1);

   reader_state_e          state;
   logic [memSize_p-1:0]   addr;
   logic [memSize_p:0]     remaining;
   logic                   in_flight;
   logic                   in_flight_last;

   logic [1:0]             buf_count;
   logic                   pop;
   logic [dataWidth_p:0]   head;
   logic [2:0]             occupancy;
   logic                   eff_read;
   logic                   final_read;

   // a pop this cycle frees a slot in time for a read issued now
   assign occupancy   = {1'b0, buf_count} + {2'b00, in_flight} - {2'b00, pop};
   assign bram_read_o = (state == ISSUE) && credit_available(occupancy);
   assign eff_read    = bram_read_o && !bram_wr_i;
   assign final_read  = eff_read && (remaining == COUNT_ONE);

   assign bram_raddr_o = addr;
   assign busy_o       = (state != IDLE);
   assign data_o       = head[dataWidth_p-1:0];
   assign last_o       = head[dataWidth_p];

   stream_skid2 #(
      .width_p(dataWidth_p + 1)
   ) u_skid (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .push_i     (in_flight),
      .push_data_i({in_flight_last, bram_data_i}),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .head_o     (head),
      .count_o    (buf_count),
      .pop_o      (pop)
   );

   // the in-flight flag tags the next cycle's bram_data_i, together with its last marker
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         addr           <= '0;
         remaining      <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         done_o         <= 1'b0;
         in_flight      <= eff_read;
         in_flight_last <= final_read;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  if (length_i != '0) begin
                     addr      <= base_addr_i;
                     remaining <= length_i;
                     state     <= ISSUE;
                  end else begin
                     done_o <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (eff_read) begin
                  addr      <= addr + ADDR_ONE;
                  remaining <= remaining - COUNT_ONE;
                  if (final_read) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && last_o) begin
                  done_o <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader with a behavioural BRAM holding
// mem[i] = i ^ 16'hA5A5 and a scoreboard of expected stream words.
module tb_bram_stream_reader;

   logic        clk_i;
   logic        reset_n_i;
   logic        start_i;
   logic [7:0]  base_addr_i;
   logic [8:0]  length_i;
   logic        busy_o;
   logic        done_o;
   logic        bram_wr_i;
   logic        bram_read_o;
   logic [7:0]  bram_raddr_o;
   logic [15:0] bram_data_i;
   logic [15:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        last_o;

   logic [15:0] mem [256];
   logic [16:0] exp_q[$];
   logic [7:0]  raddr_log[$];

   int  checks = 0;
   int  failures = 0;
   int  done_count = 0;
   int  read_count = 0;
   bit  toggle_ready = 0;
   bit  prev_stall = 0;
   logic [15:0] prev_data = '0;

   bram_stream_reader #(
      .memSize_p  (8),
      .dataWidth_p(16)
   ) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .length_i    (length_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .bram_wr_i   (bram_wr_i),
      .bram_read_o (bram_read_o),
      .bram_raddr_o(bram_raddr_o),
      .bram_data_i (bram_data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .last_o      (last_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // read port model; junk when not reading so the DUT cannot lean on held data
   always @(posedge clk_i) begin
      if (bram_read_o && !bram_wr_i) bram_data_i <= mem[bram_raddr_o];
      else bram_data_i <= 16'($urandom);
   end

   // stream monitor: scoreboard pop, stall stability, read and done bookkeeping
   always @(negedge clk_i) begin
      if (!reset_n_i) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== prev_data) begin
               failures++;
               $display("[TB] FAIL stall_hold got valid=%b data=%h expected valid=1 data=%h", valid_o, data_o, prev_data);
            end
         end
         if (valid_o === 1'b1 && ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_word got last=%b data=%h expected none", last_o, data_o);
            end else begin
               logic [16:0] exp_word;
               exp_word = exp_q.pop_front();
               if ({last_o, data_o} !== exp_word) begin
                  failures++;
                  $display("[TB] FAIL stream_word got last=%b data=%h expected last=%b data=%h", last_o, data_o, exp_word[16], exp_word[15:0]);
               end
            end
         end
         prev_stall = (valid_o === 1'b1) && (ready_i !== 1'b1);
         prev_data  = data_o;
         if (bram_read_o === 1'b1 && bram_wr_i === 1'b0) raddr_log.push_back(bram_raddr_o);
         if (bram_read_o === 1'b1) read_count++;
         if (done_o === 1'b1) done_count++;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      if (toggle_ready) ready_i = ~ready_i;
   endtask

   task automatic start_burst(input logic [7:0] base, input logic [8:0] len);
      logic [7:0] a;
      for (int k = 0; k < int'(len); k++) begin
         a = base + 8'(k);
         exp_q.push_back({(k == int'(len) - 1), mem[a]});
      end
      start_i     = 1'b1;
      base_addr_i = base;
      length_i    = len;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      timed_out = 1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_o === 1'b1) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   task automatic clear_logs();
      done_count = 0;
      read_count = 0;
      raddr_log.delete();
   endtask

   task automatic test_reset();
      $display("[TB] reset state");
      reset_n_i = 1'b0; start_i = 1'b0; base_addr_i = '0; length_i = '0;
      bram_wr_i = 1'b0; ready_i = 1'b0;
      step();
      step();
      checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b expected=0", busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b expected=0", done_o); end
      checks++; if (bram_read_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_read got=%b expected=0", bram_read_o); end
      checks++; if (bram_raddr_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_raddr got=%h expected=00", bram_raddr_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b expected=0", valid_o); end
      checks++; if (last_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b expected=0", last_o); end
      checks++; if (data_o !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data got=%h expected=0000", data_o); end
      reset_n_i = 1'b1;
      step();
   endtask

   task automatic test_basic();
      $display("[TB] basic burst base=10 len=4");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h10, 9'd4);
      checks++;
      if (bram_read_o !== 1'b1 || bram_raddr_o !== 8'h10) begin
         failures++; $display("[TB] FAIL first_read got read=%b raddr=%h expected read=1 raddr=10", bram_read_o, bram_raddr_o);
      end
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 1) begin
            checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL early_valid got=%b expected=0", valid_o); end
         end
         if (k >= 2 && k <= 5) begin
            checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL throughput_valid k=%0d got=%b expected=1", k, valid_o); end
            checks++; if (last_o !== (k == 5)) begin failures++; $display("[TB] FAIL last_flag k=%0d got=%b expected=%b", k, last_o, (k == 5)); end
         end
         if (k == 6) begin
            checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse got done=%b busy=%b expected done=1 busy=0", done_o, busy_o); end
         end
         if (k == 7) begin
            checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL done_width got=%b expected=0", done_o); end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL basic_drain got=%0d left expected=0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      bit to;
      $display("[TB] address wrap base=FE len=3");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'hFE, 9'd3);
      wait_done(40, to);
      step(); step();
      checks++; if (to) begin failures++; $display("[TB] FAIL wrap_timeout got=timeout expected=done"); end
      checks++;
      if (raddr_log.size() != 3) begin
         failures++; $display("[TB] FAIL wrap_reads got=%0d expected=3", raddr_log.size());
      end else if (raddr_log[0] !== 8'hFE || raddr_log[1] !== 8'hFF || raddr_log[2] !== 8'h00) begin
         failures++; $display("[TB] FAIL wrap_raddr got=%h,%h,%h expected=FE,FF,00", raddr_log[0], raddr_log[1], raddr_log[2]);
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL wrap_drain got=%0d left expected=0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      bit to;
      $display("[TB] backpressure len=8 ready toggling");
      toggle_ready = 1; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h40, 9'd8);
      wait_done(100, to);
      toggle_ready = 0; ready_i = 1'b1;
      step(); step();
      checks++; if (to) begin failures++; $display("[TB] FAIL bp_timeout got=timeout expected=done"); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL bp_drain got=%0d left expected=0", exp_q.size()); end
      checks++; if (done_count != 1) begin failures++; $display("[TB] FAIL bp_done_count got=%0d expected=1", done_count); end
   endtask

   task automatic test_write_conflict();
      bit to;
      $display("[TB] write port collision on second read");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h20, 9'd4);
      step();
      bram_wr_i = 1'b1;
      checks++; if (bram_read_o !== 1'b1 || bram_raddr_o !== 8'h21) begin failures++; $display("[TB] FAIL wr_second_read got read=%b raddr=%h expected read=1 raddr=21", bram_read_o, bram_raddr_o); end
      step();
      bram_wr_i = 1'b0;
      checks++; if (bram_read_o !== 1'b1 || bram_raddr_o !== 8'h21) begin failures++; $display("[TB] FAIL wr_reissue got read=%b raddr=%h expected read=1 raddr=21", bram_read_o, bram_raddr_o); end
      wait_done(40, to);
      step(); step();
      checks++; if (to) begin failures++; $display("[TB] FAIL wr_timeout got=timeout expected=done"); end
      checks++;
      if (raddr_log.size() != 4) begin
         failures++; $display("[TB] FAIL wr_reads got=%0d expected=4", raddr_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (raddr_log[i] !== 8'h20 + 8'(i)) begin
               failures++; $display("[TB] FAIL wr_raddr idx=%0d got=%h expected=%h", i, raddr_log[i], 8'h20 + 8'(i));
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL wr_drain got=%0d left expected=0", exp_q.size()); end
   endtask

   task automatic test_zero_length();
      $display("[TB] zero-length burst");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h55, 9'd0);
      checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_done got done=%b busy=%b expected done=1 busy=0", done_o, busy_o); end
      step();
      checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_done_width got=%b expected=0", done_o); end
      step(); step();
      checks++; if (read_count != 0) begin failures++; $display("[TB] FAIL zero_reads got=%0d expected=0", read_count); end
      checks++; if (done_count != 1) begin failures++; $display("[TB] FAIL zero_done_count got=%0d expected=1", done_count); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_valid got=%b expected=0", valid_o); end
   endtask

   task automatic test_reset_mid_burst();
      bit to;
      $display("[TB] reset after two of six words");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h80, 9'd6);
      for (int k = 1; k <= 4; k++) step();
      reset_n_i = 1'b0;
      ready_i   = 1'b0;
      exp_q.delete();
      step();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || bram_read_o !== 1'b0 || bram_raddr_o !== 8'h00 ||
          valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL mid_reset_outputs got busy=%b done=%b read=%b raddr=%h valid=%b last=%b data=%h expected all zero",
                  busy_o, done_o, bram_read_o, bram_raddr_o, valid_o, last_o, data_o);
      end
      step();
      done_count = 0;
      reset_n_i  = 1'b1;
      ready_i    = 1'b1;
      for (int k = 0; k < 4; k++) step();
      checks++; if (done_count != 0 || valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_quiet got done_count=%0d valid=%b expected 0 and 0", done_count, valid_o); end
      clear_logs();
      start_burst(8'h00, 9'd2);
      wait_done(40, to);
      step(); step();
      checks++; if (to) begin failures++; $display("[TB] FAIL post_reset_timeout got=timeout expected=done"); end
      checks++; if (done_count != 1 || exp_q.size() != 0) begin failures++; $display("[TB] FAIL post_reset_burst got done_count=%0d left=%0d expected 1 and 0", done_count, exp_q.size()); end
   endtask

   task automatic test_start_while_busy();
      bit to;
      $display("[TB] start pulsed while busy");
      toggle_ready = 0; ready_i = 1'b1;
      clear_logs();
      start_burst(8'h30, 9'd5);
      step();
      start_i = 1'b1; base_addr_i = 8'h90; length_i = 9'd3;
      step();
      start_i = 1'b0;
      wait_done(40, to);
      step(); step();
      checks++; if (to) begin failures++; $display("[TB] FAIL busy_timeout got=timeout expected=done"); end
      checks++;
      if (raddr_log.size() != 5) begin
         failures++; $display("[TB] FAIL busy_reads got=%0d expected=5", raddr_log.size());
      end else if (raddr_log[0] !== 8'h30 || raddr_log[4] !== 8'h34) begin
         failures++; $display("[TB] FAIL busy_raddr got first=%h last=%h expected first=30 last=34", raddr_log[0], raddr_log[4]);
      end
      for (int k = 0; k < 3; k++) step();
      checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || done_count != 1) begin failures++; $display("[TB] FAIL busy_ignored got busy=%b valid=%b done_count=%0d expected 0,0,1", busy_o, valid_o, done_count); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL busy_drain got=%0d left expected=0", exp_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_write_conflict();
      test_zero_length();
      test_reset_mid_burst();
      test_start_while_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
